// File: rtl/ccip_fiu_model_pkg.sv
// Shared widths and request/response payload types for the CCI-P FIU memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ccip_fiu_model_pkg;

  localparam int CCIP_ADDR_W  = 42;
  localparam int CCIP_MDATA_W = 16;
  localparam int CCIP_LINE_W  = 512;

  typedef logic [CCIP_ADDR_W-1:0]  t_ccip_addr;
  typedef logic [CCIP_MDATA_W-1:0] t_ccip_mdata;
  typedef logic [CCIP_LINE_W-1:0]  t_ccip_line;

  // c0 read request as held in the read FIFO
  typedef struct packed {
    t_ccip_addr  addr;
    t_ccip_mdata mdata;
  } t_rd_req;

  // c1 write or fence request as held in the write FIFO; addr/data unused for a fence
  typedef struct packed {
    logic        fence;
    t_ccip_addr  addr;
    t_ccip_mdata mdata;
    t_ccip_line  data;
  } t_wr_req;

  // payload carried down the read response pipeline
  typedef struct packed {
    t_ccip_mdata mdata;
    t_ccip_line  data;
  } t_rd_rsp;

endpackage

// File: rtl/ccip_req_fifo.sv
// Synchronous request FIFO with registered occupancy and almost-full flag.
// Latency: an entry pushed in cycle T is visible at the head (poppable) in T+1.
// Backpressure: push while full is dropped (caller flags it); alm_full tracks occupancy with one register stage.
module ccip_req_fifo #(
  parameter type T             = logic,
  parameter int  DEPTH         = 16,
  parameter int  ALMFULL_SLACK = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     head_dat,
  output logic empty,
  output logic full,
  output logic alm_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMFULL_C = CNT_W'(DEPTH - ALMFULL_SLACK);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alm_full_q, alm_full_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q];
  assign alm_full = alm_full_q;

  // pointer, occupancy and almost-full next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    alm_full_d = (count_d >= ALMFULL_C);
  end

  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alm_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alm_full_q <= alm_full_d;
    end
  end

  // entry storage, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/ccip_fiu_mem_responder.sv
// FIU-side CCI-P memory responder: c0 reads and c1 writes/fences served from a local line memory.
// Latency: read request T -> c0 response T+1+READ_LATENCY; write/fence request T -> c1 response T+2 (empty FIFOs).
// Backpressure: none on responses; requesters throttle on registered alm_full, overflowing requests are dropped and set ovf_err.
module ccip_fiu_mem_responder
  import ccip_fiu_model_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 10,
  parameter int READ_LATENCY  = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    c0_req_valid,
  input  logic [CCIP_ADDR_W-1:0]  c0_req_addr,
  input  logic [CCIP_MDATA_W-1:0] c0_req_mdata,
  input  logic                    c1_req_valid,
  input  logic                    c1_req_fence,
  input  logic [CCIP_ADDR_W-1:0]  c1_req_addr,
  input  logic [CCIP_MDATA_W-1:0] c1_req_mdata,
  input  logic [CCIP_LINE_W-1:0]  c1_req_data,
  output logic                    c0_tx_alm_full,
  output logic                    c1_tx_alm_full,
  output logic                    c0_rsp_valid,
  output logic [CCIP_MDATA_W-1:0] c0_rsp_mdata,
  output logic [CCIP_LINE_W-1:0]  c0_rsp_data,
  output logic                    c1_rsp_valid,
  output logic [CCIP_MDATA_W-1:0] c1_rsp_mdata,
  output logic                    c1_rsp_is_fence,
  output logic                    ovf_err
);

  localparam int MEM_LINES = 1 << MEM_ADDR_BITS;

  t_rd_req rd_push_dat, rd_head;
  t_wr_req wr_push_dat, wr_head;
  logic    rd_empty, rd_full, rd_pop;
  logic    wr_empty, wr_full, wr_pop;

  // Read-pop hold point; tied off in the design, a bench may force it to stall the read FIFO.
  logic    rd_stall;
  assign rd_stall = 1'b0;

  assign rd_push_dat = '{addr: c0_req_addr, mdata: c0_req_mdata};
  assign wr_push_dat = '{fence: c1_req_fence, addr: c1_req_addr,
                         mdata: c1_req_mdata, data: c1_req_data};

  ccip_req_fifo #(
    .T(t_rd_req), .DEPTH(FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c0_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(c0_req_valid), .push_dat(rd_push_dat),
    .pop(rd_pop), .head_dat(rd_head),
    .empty(rd_empty), .full(rd_full), .alm_full(c0_tx_alm_full)
  );

  ccip_req_fifo #(
    .T(t_wr_req), .DEPTH(FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c1_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(c1_req_valid), .push_dat(wr_push_dat),
    .pop(wr_pop), .head_dat(wr_head),
    .empty(wr_empty), .full(wr_full), .alm_full(c1_tx_alm_full)
  );

  assign rd_pop = !rd_empty && !rd_stall;
  assign wr_pop = !wr_empty;

  // Backing memory: one write port, one read port. Upper address bits alias by design.
  t_ccip_line               mem_q [MEM_LINES];
  logic [MEM_ADDR_BITS-1:0] rd_idx, wr_idx;
  logic                     wr_en;
  t_ccip_line               rd_line;
  logic                     addr_hi_unused;

  assign rd_idx = rd_head.addr[MEM_ADDR_BITS-1:0];
  assign wr_idx = wr_head.addr[MEM_ADDR_BITS-1:0];
  assign wr_en  = wr_pop && !wr_head.fence;
  assign addr_hi_unused = ^{rd_head.addr[CCIP_ADDR_W-1:MEM_ADDR_BITS],
                            wr_head.addr[CCIP_ADDR_W-1:MEM_ADDR_BITS]};

  // write-first: a read popped alongside a write to the same line sees the new data
  always_comb begin
    rd_line = mem_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_line = wr_head.data;
  end

  // line memory update, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_head.data;
  end

  // Read pipeline: stage 0 captures the popped request with its line data.
  logic [READ_LATENCY-1:0] rp_vld_q, rp_vld_d;
  t_rd_rsp                 rp_dat_q [READ_LATENCY];
  t_rd_rsp                 rp_dat_d [READ_LATENCY];

  // shift the read pipeline one stage per cycle
  always_comb begin
    rp_vld_d = rp_vld_q;
    rp_dat_d = rp_dat_q;
    rp_vld_d[0] = rd_pop;
    rp_dat_d[0] = '{mdata: rd_head.mdata, data: rd_line};
    for (int i = 1; i < READ_LATENCY; i++) begin
      rp_vld_d[i] = rp_vld_q[i-1];
      rp_dat_d[i] = rp_dat_q[i-1];
    end
  end

  // pipeline valids flush on reset; payload is don't-care while invalid
  always_ff @(posedge clk) begin
    if (!reset_n) rp_vld_q <= '0;
    else          rp_vld_q <= rp_vld_d;
  end

  // pipeline payload registers
  always_ff @(posedge clk) begin
    rp_dat_q <= rp_dat_d;
  end

  assign c0_rsp_valid = rp_vld_q[READ_LATENCY-1];
  assign c0_rsp_mdata = rp_dat_q[READ_LATENCY-1].mdata;
  assign c0_rsp_data  = rp_dat_q[READ_LATENCY-1].data;

  // Write response register and sticky overflow flag.
  logic        wrsp_vld_q, wrsp_vld_d;
  t_ccip_mdata wrsp_mdata_q, wrsp_mdata_d;
  logic        wrsp_fence_q, wrsp_fence_d;
  logic        ovf_q, ovf_d;

  // respond to each popped write/fence one cycle later; latch any dropped request
  always_comb begin
    wrsp_vld_d   = wr_pop;
    wrsp_mdata_d = wr_head.mdata;
    wrsp_fence_d = wr_head.fence;
    ovf_d        = ovf_q || (c0_req_valid && rd_full) || (c1_req_valid && wr_full);
  end

  // write response and overflow state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrsp_vld_q   <= 1'b0;
      wrsp_mdata_q <= '0;
      wrsp_fence_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wrsp_vld_q   <= wrsp_vld_d;
      wrsp_mdata_q <= wrsp_mdata_d;
      wrsp_fence_q <= wrsp_fence_d;
      ovf_q        <= ovf_d;
    end
  end

  assign c1_rsp_valid    = wrsp_vld_q;
  assign c1_rsp_mdata    = wrsp_mdata_q;
  assign c1_rsp_is_fence = wrsp_fence_q;
  assign ovf_err         = ovf_q;

endmodule

// File: tb/tb_ccip_fiu_mem_responder.sv
// Directed bench for ccip_fiu_mem_responder with queue-based response scoreboard.
// Latency: expects c0 at issue+5 and c1 at issue+2 for timed requests.
// Backpressure: holds the read FIFO by forcing the internal pop stall point.
module tb_ccip_fiu_mem_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic         c1_req_fence;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_tx_alm_full, c1_tx_alm_full;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         c1_rsp_is_fence;
  logic         ovf_err;

  ccip_fiu_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_fence(c1_req_fence), .c1_req_addr(c1_req_addr),
    .c1_req_mdata(c1_req_mdata), .c1_req_data(c1_req_data),
    .c0_tx_alm_full(c0_tx_alm_full), .c1_tx_alm_full(c1_tx_alm_full),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata), .c1_rsp_is_fence(c1_rsp_is_fence),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]  mdata;
    logic [511:0] data;
    logic         fence;
    int           cyc;
  } exp_t;

  exp_t         rd_q[$];
  exp_t         wr_q[$];
  logic [511:0] model [1024];
  int           vecs  = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one cycle of requests and record the expected responses.
  task automatic issue(input bit rd, input logic [41:0] ra, input logic [15:0] rm,
                       input bit wr, input bit fence, input logic [41:0] wa,
                       input logic [15:0] wm, input logic [511:0] wd,
                       input bit timed, input bit rd_exp);
    exp_t e;
    if (wr) begin
      c1_req_valid = 1'b1; c1_req_fence = fence;
      c1_req_addr  = wa;   c1_req_mdata = wm; c1_req_data = wd;
      if (!fence) model[wa[9:0]] = wd;
      e = '{mdata: wm, data: '0, fence: fence, cyc: timed ? cyc + 2 : -1};
      wr_q.push_back(e);
    end
    if (rd) begin
      c0_req_valid = 1'b1; c0_req_addr = ra; c0_req_mdata = rm;
      if (rd_exp) begin
        e = '{mdata: rm, data: model[ra[9:0]], fence: 1'b0, cyc: timed ? cyc + 5 : -1};
        rd_q.push_back(e);
      end
    end
    tick();
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
    c1_req_fence = 1'b0;
  endtask

  task automatic rd(input logic [41:0] a, input logic [15:0] m, input bit timed, input bit rd_exp);
    issue(1'b1, a, m, 1'b0, 1'b0, '0, '0, '0, timed, rd_exp);
  endtask

  task automatic wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d, input bit fence);
    issue(1'b0, '0, '0, 1'b1, fence, a, m, d, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: compares every response against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (c0_rsp_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        vecs++; fails++;
        $display("FAIL c0_unexpected: got mdata %0h expected no response (cycle %0d)", c0_rsp_mdata, cyc);
      end else begin
        e = rd_q.pop_front();
        chk("c0_mdata", 512'(c0_rsp_mdata), 512'(e.mdata));
        chk("c0_data", c0_rsp_data, e.data);
        if (e.cyc >= 0) chk("c0_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
    if (c1_rsp_valid === 1'b1) begin
      if (wr_q.size() == 0) begin
        vecs++; fails++;
        $display("FAIL c1_unexpected: got mdata %0h expected no response (cycle %0d)", c1_rsp_mdata, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("c1_mdata", 512'(c1_rsp_mdata), 512'(e.mdata));
        chk("c1_is_fence", 512'(c1_rsp_is_fence), 512'(e.fence));
        if (e.cyc >= 0) chk("c1_cycle", 512'(cyc), 512'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset_n = 1'b0;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_fence = 1'b0; c1_req_addr = '0;
    c1_req_mdata = '0; c1_req_data = '0;
    idle(3);

    // reset state
    chk("rst_c0_rsp_valid", 512'(c0_rsp_valid), 512'(0));
    chk("rst_c1_rsp_valid", 512'(c1_rsp_valid), 512'(0));
    chk("rst_c0_alm_full", 512'(c0_tx_alm_full), 512'(0));
    chk("rst_c1_alm_full", 512'(c1_tx_alm_full), 512'(0));
    chk("rst_ovf_err", 512'(ovf_err), 512'(0));
    reset_n = 1'b1;
    idle(2);

    // basic write, response at T+2
    wr(42'd5, 16'h0011, pat(8'hA5), 1'b0);
    idle(4);
    // seed addr 3, then timed read at T+5
    wr(42'd3, 16'h0012, pat(8'h3C), 1'b0);
    idle(4);
    rd(42'd3, 16'h0022, 1'b1, 1'b1);
    idle(8);
    rd(42'd5, 16'h0023, 1'b1, 1'b1);
    idle(8);

    // write, write, fence back to back; fence responds last
    wr(42'd7, 16'h0031, pat(8'h77), 1'b0);
    wr(42'd9, 16'h0032, pat(8'h99), 1'b0);
    wr(42'd0, 16'h0033, pat(8'hEE), 1'b1);
    idle(4);
    rd(42'd7, 16'h0034, 1'b1, 1'b1);
    rd(42'd9, 16'h0035, 1'b1, 1'b1);
    idle(8);

    // same-cycle write and read of aliased line 0x405 -> index 5
    issue(1'b1, 42'h405, 16'h0042, 1'b1, 1'b0, 42'h405, 16'h0041, pat(8'h5A), 1'b1, 1'b1);
    idle(3);
    rd(42'd5, 16'h0043, 1'b1, 1'b1);
    idle(8);

    // 16 reads with pops held: alm_full from the cycle after the 8th accept
    force dut.rd_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("c0_alm_full_fill", 512'(c0_tx_alm_full), 512'(i >= 8));
      rd((i % 2 == 0) ? 42'd7 : 42'd9, 16'(16'h0100 + i), 1'b0, 1'b1);
    end
    chk("c0_alm_full_16", 512'(c0_tx_alm_full), 512'(1));
    chk("ovf_after_16", 512'(ovf_err), 512'(0));
    release dut.rd_stall;
    idle(30);
    chk("c0_alm_full_drained", 512'(c0_tx_alm_full), 512'(0));

    // 17 reads with pops held: last one overflows, flag is sticky
    force dut.rd_stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ovf_before_17th", 512'(ovf_err), 512'(0));
      rd(42'd3, 16'(16'h0200 + i), 1'b0, i < 16);
    end
    chk("ovf_after_17th", 512'(ovf_err), 512'(1));
    release dut.rd_stall;
    idle(30);
    chk("ovf_sticky", 512'(ovf_err), 512'(1));
    chk("rd_q_drained", 512'(rd_q.size()), 512'(0));

    // reset with 4 reads in flight: all dropped
    for (int i = 0; i < 4; i++) rd(42'd5, 16'(16'h0300 + i), 1'b0, 1'b0);
    reset_n = 1'b0;
    idle(2);
    chk("rst2_c0_rsp_valid", 512'(c0_rsp_valid), 512'(0));
    chk("rst2_c0_alm_full", 512'(c0_tx_alm_full), 512'(0));
    chk("rst2_ovf_err", 512'(ovf_err), 512'(0));
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (c0_rsp_valid === 1'b1) seen++;
    end
    chk("no_c0_after_reset", 512'(seen), 512'(0));

    // memory survives reset
    rd(42'd5, 16'h0044, 1'b1, 1'b1);
    idle(10);
    chk("final_rd_q_empty", 512'(rd_q.size()), 512'(0));
    chk("final_wr_q_empty", 512'(wr_q.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
